// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the 16-word data memory.
interface dmem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_err;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_ack;
  logic              dbg_err;

  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_ack, cpu_err,
    output dbg_rdata, dbg_ack, dbg_err,
    output mem_we, mem_re, mem_addr, mem_wdata, busy
  );

  // Requesters plus memory side.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_ack, cpu_err,
    input  dbg_rdata, dbg_ack, dbg_err,
    input  mem_we, mem_re, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer sharing the data memory between CPU and debug ports.
// Each access runs IDLE -> GRANT -> RESP with all outputs registered.
module dmem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;

  state_t            state;
  logic              prioDbg;   // debug wins a tie when set
  logic              latDbg;
  logic              latWe;
  logic              latErr;

  logic              pickDbg;
  logic              selWe;
  logic              selOk;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selWdata;

  always_comb begin
    pickDbg  = bus.dbg_req & (~bus.cpu_req | prioDbg);
    selWe    = pickDbg ? bus.dbg_we    : bus.cpu_we;
    selAddr  = pickDbg ? bus.dbg_addr  : bus.cpu_addr;
    selWdata = pickDbg ? bus.dbg_wdata : bus.cpu_wdata;
    selOk    = selAddr < ADDR_W'(DEPTH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      prioDbg       <= 1'b0;
      latDbg        <= 1'b0;
      latWe         <= 1'b0;
      latErr        <= 1'b0;
      bus.cpu_ack   <= 1'b0;
      bus.cpu_err   <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.dbg_ack   <= 1'b0;
      bus.dbg_err   <= 1'b0;
      bus.dbg_rdata <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_re    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cpu_req | bus.dbg_req) begin
            // Strobes are set up here so they are valid for the whole GRANT cycle.
            state         <= GRANT;
            bus.busy      <= 1'b1;
            latDbg        <= pickDbg;
            prioDbg       <= ~pickDbg;
            latWe         <= selWe;
            latErr        <= ~selOk;
            bus.mem_addr  <= selAddr;
            bus.mem_wdata <= selWdata;
            bus.mem_we    <= selWe & selOk;
            bus.mem_re    <= ~selWe & selOk;
          end
        end
        GRANT: begin
          state       <= RESP;
          bus.mem_we  <= 1'b0;
          bus.mem_re  <= 1'b0;
          bus.cpu_ack <= ~latDbg;
          bus.dbg_ack <= latDbg;
          bus.cpu_err <= ~latDbg & latErr;
          bus.dbg_err <= latDbg & latErr;
          if (!latWe) begin
            if (latDbg) bus.dbg_rdata <= latErr ? '0 : bus.mem_rdata;
            else        bus.cpu_rdata <= latErr ? '0 : bus.mem_rdata;
          end
        end
        RESP: begin
          state       <= IDLE;
          bus.busy    <= 1'b0;
          bus.cpu_ack <= 1'b0;
          bus.dbg_ack <= 1'b0;
          bus.cpu_err <= 1'b0;
          bus.dbg_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: transaction-level reference model with
// per-port request queues, a shared reference memory and a round-robin pointer.
module tb_dmem_arbiter;

  localparam int DEPTH = 16;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic clk;
  logic reset;
  logic initMem;
  logic [31:0] seedBase;
  logic [31:0] envMem [DEPTH];

  dmem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment memory: combinational read, clocked write, never cleared by reset.
  assign bus.mem_rdata = bus.mem_re ? envMem[bus.mem_addr[3:0]] : '0;
  always @(posedge clk) begin
    if (initMem) begin
      for (int i = 0; i < DEPTH; i++) envMem[i] <= seedBase ^ (i * 32'h0101_0101);
    end else if (bus.mem_we) begin
      envMem[bus.mem_addr[3:0]] <= bus.mem_wdata;
    end
  end

  // Reference model state.
  txn_t        cpuQ[$];
  txn_t        dbgQ[$];
  logic [31:0] refMem [DEPTH];
  logic [31:0] expCpuRd, expDbgRd, pendRd;
  logic        lastDbg;
  logic        grantValid, gDbg, gWe, gOk, inG, inR;
  logic [31:0] gAddr, gWdata;
  int          cyc, freeAt, grantEdge;
  int          nChecks, nPass;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    else nPass++;
  endtask

  function automatic txn_t randTxn();
    txn_t t;
    int unsigned r;
    r = $urandom_range(0, 9);
    t.we    = $urandom_range(0, 1) == 1;
    t.wdata = $urandom;
    if (r == 0)      t.addr = $urandom;
    else if (r == 1) t.addr = DEPTH;
    else             t.addr = $urandom_range(0, DEPTH - 1);
    return t;
  endfunction

  function automatic txn_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata;
    return t;
  endfunction

  task automatic resetModel();
    cpuQ.delete();
    dbgQ.delete();
    lastDbg    = 1'b1;
    grantValid = 1'b0;
    expCpuRd   = '0;
    expDbgRd   = '0;
    freeAt     = 0;
  endtask

  task automatic step();
    txn_t t;
    @(negedge clk);
    bus.cpu_req = cpuQ.size() > 0;
    t = (cpuQ.size() > 0) ? cpuQ[0] : randTxn();
    bus.cpu_we = t.we; bus.cpu_addr = t.addr; bus.cpu_wdata = t.wdata;
    bus.dbg_req = dbgQ.size() > 0;
    t = (dbgQ.size() > 0) ? dbgQ[0] : randTxn();
    bus.dbg_we = t.we; bus.dbg_addr = t.addr; bus.dbg_wdata = t.wdata;
    @(posedge clk);
    cyc++;
    #1;
    // Arbiter accepts a new request once three cycles have passed since the last grant.
    if (cyc >= freeAt && (cpuQ.size() > 0 || dbgQ.size() > 0)) begin
      gDbg = (dbgQ.size() > 0) && (cpuQ.size() == 0 || !lastDbg);
      t = gDbg ? dbgQ[0] : cpuQ[0];
      gWe = t.we; gAddr = t.addr; gWdata = t.wdata;
      gOk = t.addr < DEPTH;
      if (!t.we)    pendRd = gOk ? refMem[t.addr[3:0]] : '0;
      else if (gOk) refMem[t.addr[3:0]] = t.wdata;
      lastDbg = gDbg; grantValid = 1'b1; grantEdge = cyc; freeAt = cyc + 3;
    end
    inG = grantValid && cyc == grantEdge;
    inR = grantValid && cyc == grantEdge + 1;
    if (inR && !gWe) begin
      if (gDbg) expDbgRd = pendRd;
      else      expCpuRd = pendRd;
    end
    check("mem_we", bus.mem_we, inG & gWe & gOk);
    check("mem_re", bus.mem_re, inG & !gWe & gOk);
    check("strobeExcl", bus.mem_we & bus.mem_re, 0);
    if (inG) begin
      check("mem_addr", bus.mem_addr, gAddr);
      check("mem_wdata", bus.mem_wdata, gWdata);
    end
    check("cpu_ack", bus.cpu_ack, inR & !gDbg);
    check("dbg_ack", bus.dbg_ack, inR & gDbg);
    check("cpu_err", bus.cpu_err, inR & !gDbg & !gOk);
    check("dbg_err", bus.dbg_err, inR & gDbg & !gOk);
    check("cpu_rdata", bus.cpu_rdata, expCpuRd);
    check("dbg_rdata", bus.dbg_rdata, expDbgRd);
    check("busy", bus.busy, inG | inR);
    if (inR) begin
      if (gDbg) void'(dbgQ.pop_front());
      else      void'(cpuQ.pop_front());
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((cpuQ.size() > 0 || dbgQ.size() > 0) && n < budget) begin
      step();
      n++;
    end
    check("drainDone", (cpuQ.size() == 0 && dbgQ.size() == 0), 1);
    step();
  endtask

  initial begin
    nChecks = 0; nPass = 0; cyc = 0; grantEdge = -10;
    reset = 1'b1; initMem = 1'b1;
    seedBase = $urandom;
    for (int i = 0; i < DEPTH; i++) refMem[i] = seedBase ^ (i * 32'h0101_0101);
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    resetModel();
    #2;
    check("rstBusy", bus.busy, 0);
    check("rstStrobes", {bus.mem_we, bus.mem_re}, 0);
    check("rstAcks", {bus.cpu_ack, bus.dbg_ack, bus.cpu_err, bus.dbg_err}, 0);
    check("rstRdata", {bus.cpu_rdata, bus.dbg_rdata}, 0);
    check("rstMem", {bus.mem_addr, bus.mem_wdata}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; initMem = 1'b0;

    cpuQ.push_back(mk(1'b1, 32'd3, 32'hDEAD_BEEF));
    drain(20);
    cpuQ.push_back(mk(1'b0, 32'd3, 32'h0));
    drain(20);
    cpuQ.push_back(mk(1'b0, 32'd1, 32'h0));
    dbgQ.push_back(mk(1'b0, 32'd2, 32'h0));
    drain(20);
    cpuQ.push_back(mk(1'b0, 32'd4, 32'h0));
    dbgQ.push_back(mk(1'b0, 32'd5, 32'h0));
    drain(20);
    dbgQ.push_back(mk(1'b0, 32'd16, 32'h0));
    cpuQ.push_back(mk(1'b1, 32'h0000_0100, 32'h1234_5678));
    drain(20);
    cpuQ.push_back(mk(1'b0, 32'd0, 32'h0));
    cpuQ.push_back(mk(1'b0, 32'd1, 32'h0));
    cpuQ.push_back(mk(1'b0, 32'd2, 32'h0));
    drain(30);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0 && cpuQ.size() < 2) cpuQ.push_back(randTxn());
      if ($urandom_range(0, 3) == 0 && dbgQ.size() < 2) dbgQ.push_back(randTxn());
      step();
    end
    drain(40);

    // Abort a CPU read in its GRANT cycle with an asynchronous reset.
    cpuQ.push_back(mk(1'b0, 32'd7, 32'h0));
    for (int n = 0; n < 10 && !inG; n++) step();
    check("resetGrantReached", inG, 1);
    #2;
    reset = 1'b1;
    bus.cpu_req = 1'b0;
    #1;
    check("midRstMemRe", bus.mem_re, 0);
    check("midRstBusy", bus.busy, 0);
    check("midRstAck", bus.cpu_ack, 0);
    check("midRstAddr", bus.mem_addr, 0);
    resetModel();
    @(negedge clk);
    reset = 1'b0;
    cpuQ.push_back(mk(1'b0, 32'd8, 32'h0));
    dbgQ.push_back(mk(1'b0, 32'd9, 32'h0));
    drain(20);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
